// File: rtl/perceptron_pkg.sv
// ----------------------------------------------------------------------------
// perceptron_pkg : shared display states, segment codes and class limits
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package perceptron_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_BLANK = 2'd0;
  localparam state_t ST_SHOW  = 2'd1;
  localparam state_t ST_ERR   = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [3:0] CLASS_MAX = 4'd9;

  // Segment order {g,f,e,d,c,b,a}, active high
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    if (d <= CLASS_MAX) return SEG_DIGIT[d];
    return SEG_BLANK;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler : one-cycle tick every TICK_COUNT enabled clocks
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tick_prescaler #(
  parameter logic [23:0] TICK_COUNT = 24'd10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic tick
);

  logic [23:0] r_cnt;
  logic        w_wrap;

  assign w_wrap = (r_cnt == TICK_COUNT - 24'd1);
  assign tick   = ena & w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 24'd0;
    end else if (ena) begin
      r_cnt <= w_wrap ? 24'd0 : r_cnt + 24'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/class_display_filter.sv
// ----------------------------------------------------------------------------
// class_display_filter : debounces the class code and drives a 7-seg digit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module class_display_filter
  import perceptron_pkg::*;
#(
  parameter logic [23:0] TICK_COUNT   = 24'd10_000_000,
  parameter int          STABLE_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] class_in,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [3:0] class_q,
  output logic       change_pulse
);

  localparam logic [3:0] c_STABLE = STABLE_TICKS[3:0];

  logic       w_tick;
  logic [3:0] r_cand;
  logic [3:0] r_stab;
  state_t     r_state;
  logic       r_blink;
  logic [3:0] r_class;
  logic       r_pulse;
  logic [6:0] r_seg;
  logic       r_dp;

  logic [3:0] w_stab_nxt;
  logic       w_stable;
  state_t     w_state_nxt;
  logic       w_blink_nxt;
  logic [3:0] w_class_nxt;
  logic       w_pulse_nxt;
  logic [6:0] w_seg_nxt;
  logic       w_dp_nxt;

  tick_prescaler #(.TICK_COUNT(TICK_COUNT)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .tick  (w_tick)
  );

  // Zero reset values let the first tick load cand naturally, even for class 0
  assign w_stab_nxt = (class_in != r_cand) ? 4'd1 :
                      (r_stab == c_STABLE) ? c_STABLE : r_stab + 4'd1;
  assign w_stable   = w_tick && (w_stab_nxt == c_STABLE);

  always_comb begin
    w_state_nxt = r_state;
    w_blink_nxt = r_blink;
    w_class_nxt = r_class;
    w_pulse_nxt = 1'b0;
    if (w_tick && (r_state == ST_ERR)) w_blink_nxt = ~r_blink;
    if (w_stable) begin
      if (class_in <= CLASS_MAX) begin
        w_state_nxt = ST_SHOW;
        if ((r_state != ST_SHOW) || (class_in != r_class)) begin
          w_class_nxt = class_in;
          w_pulse_nxt = 1'b1;
        end
      end else begin
        w_state_nxt = ST_ERR;
        if (r_state != ST_ERR) w_blink_nxt = 1'b0;
      end
    end
  end

  // Outputs are encoded from next-state so they land one clock after the tick
  always_comb begin
    w_seg_nxt = SEG_BLANK;
    w_dp_nxt  = 1'b0;
    case (w_state_nxt)
      ST_SHOW: begin
        w_seg_nxt = digit_seg(w_class_nxt);
        w_dp_nxt  = 1'b1;
      end
      ST_ERR:  w_seg_nxt = w_blink_nxt ? SEG_BLANK : SEG_DASH;
      default: w_seg_nxt = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand  <= 4'd0;
      r_stab  <= 4'd0;
      r_state <= ST_BLANK;
      r_blink <= 1'b0;
      r_class <= 4'd0;
      r_pulse <= 1'b0;
      r_seg   <= SEG_BLANK;
      r_dp    <= 1'b0;
    end else if (ena) begin
      if (w_tick) begin
        r_cand <= class_in;
        r_stab <= w_stab_nxt;
      end
      r_state <= w_state_nxt;
      r_blink <= w_blink_nxt;
      r_class <= w_class_nxt;
      r_pulse <= w_pulse_nxt;
      r_seg   <= w_seg_nxt;
      r_dp    <= w_dp_nxt;
    end else begin
      r_pulse <= 1'b0;
    end
  end

  assign seg_out      = r_seg;
  assign dp_out       = r_dp;
  assign class_q      = r_class;
  assign change_pulse = r_pulse;

endmodule

`default_nettype wire

// File: tb/tb_class_display_filter.sv
// ----------------------------------------------------------------------------
// tb_class_display_filter : directed per-tick vectors plus corner sequences
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_class_display_filter;

  typedef struct {
    logic [3:0] cls;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] q;
    logic       p;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, rst_n2, ena;
  logic [3:0] class_in, class_in2;
  logic [6:0] seg_out, seg_out2;
  logic       dp_out, dp_out2, change_pulse, change_pulse2;
  logic [3:0] class_q, class_q2;

  int   errors = 0;
  int   checks = 0;
  int   pulse_cnt = 0;
  vec_t vecs [30];

  always #5 clk = ~clk;

  class_display_filter #(.TICK_COUNT(24'd4), .STABLE_TICKS(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .class_in(class_in),
    .seg_out(seg_out), .dp_out(dp_out), .class_q(class_q),
    .change_pulse(change_pulse)
  );

  class_display_filter #(.TICK_COUNT(24'd4), .STABLE_TICKS(1)) dut1 (
    .clk(clk), .rst_n(rst_n2), .ena(ena), .class_in(class_in2),
    .seg_out(seg_out2), .dp_out(dp_out2), .class_q(class_q2),
    .change_pulse(change_pulse2)
  );

  always @(negedge clk) if (change_pulse) pulse_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [6:0] seg, input logic dp,
                         input logic [3:0] q, input logic p);
    chk({tag, " seg"},   {25'd0, seg_out},      {25'd0, seg});
    chk({tag, " dp"},    {31'd0, dp_out},       {31'd0, dp});
    chk({tag, " q"},     {28'd0, class_q},      {28'd0, q});
    chk({tag, " pulse"}, {31'd0, change_pulse}, {31'd0, p});
  endtask

  // Drive a value, then advance exactly one tick period and look just after the tick edge
  task automatic one_tick(input logic [3:0] cls);
    @(negedge clk) class_in = cls;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 10; i++)
      vecs[i] = '{(i % 2 == 0) ? 4'd5 : 4'd7, 7'h00, 1'b0, 4'd0, 1'b0};
    vecs[10] = '{4'd5,  7'h00, 1'b0, 4'd0, 1'b0};
    vecs[11] = '{4'd5,  7'h00, 1'b0, 4'd0, 1'b0};
    vecs[12] = '{4'd5,  7'h6D, 1'b1, 4'd5, 1'b1};
    vecs[13] = '{4'd12, 7'h6D, 1'b1, 4'd5, 1'b0};
    vecs[14] = '{4'd12, 7'h6D, 1'b1, 4'd5, 1'b0};
    vecs[15] = '{4'd12, 7'h40, 1'b0, 4'd5, 1'b0};
    vecs[16] = '{4'd12, 7'h00, 1'b0, 4'd5, 1'b0};
    vecs[17] = '{4'd12, 7'h40, 1'b0, 4'd5, 1'b0};
    vecs[18] = '{4'd2,  7'h00, 1'b0, 4'd5, 1'b0};
    vecs[19] = '{4'd2,  7'h40, 1'b0, 4'd5, 1'b0};
    vecs[20] = '{4'd2,  7'h5B, 1'b1, 4'd2, 1'b1};
    vecs[21] = '{4'd8,  7'h5B, 1'b1, 4'd2, 1'b0};
    vecs[22] = '{4'd8,  7'h5B, 1'b1, 4'd2, 1'b0};
    vecs[23] = '{4'd8,  7'h7F, 1'b1, 4'd8, 1'b1};
    for (int i = 24; i < 30; i++)
      vecs[i] = '{4'd8, 7'h7F, 1'b1, 4'd8, 1'b0};

    rst_n = 1'b0; rst_n2 = 1'b0; ena = 1'b1; class_in = 4'd0; class_in2 = 4'd0;
    repeat (2) @(posedge clk);
    #1 chk_out("reset", 7'h00, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      one_tick(vecs[i].cls);
      chk_out($sformatf("vec%0d", i), vecs[i].seg, vecs[i].dp, vecs[i].q, vecs[i].p);
    end

    // Glitch to 3 on a non-tick cycle only
    @(negedge clk) class_in = 4'd8;
    @(posedge clk);
    @(negedge clk) class_in = 4'd3;
    @(negedge clk) class_in = 4'd8;
    repeat (2) @(posedge clk);
    #1 chk_out("glitch", 7'h7F, 1'b1, 4'd8, 1'b0);

    // Freeze mid-count with a new class on the input
    @(negedge clk) class_in = 4'd4;
    repeat (2) @(posedge clk);
    @(negedge clk) ena = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk_out("frozen", 7'h7F, 1'b1, 4'd8, 1'b0);
    @(negedge clk) ena = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_out("ena_t1", 7'h7F, 1'b1, 4'd8, 1'b0);
    one_tick(4'd4);
    chk_out("ena_t2", 7'h7F, 1'b1, 4'd8, 1'b0);
    one_tick(4'd4);
    chk_out("ena_t3", 7'h66, 1'b1, 4'd4, 1'b1);
    @(posedge clk);
    #1 chk("pulse_width", {31'd0, change_pulse}, 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("pulse_total", pulse_cnt, 32'd4);

    // Single-tick commit, then asynchronous reset between clock edges
    @(posedge clk);
    #1 rst_n2 = 1'b1;
    @(negedge clk) class_in2 = 4'd9;
    repeat (4) @(posedge clk);
    #1;
    chk("st1 seg", {25'd0, seg_out2}, 32'h6F);
    chk("st1 dp",  {31'd0, dp_out2},  32'd1);
    chk("st1 q",   {28'd0, class_q2}, 32'd9);
    #2 rst_n2 = 1'b0;
    #1;
    chk("async seg", {25'd0, seg_out2}, 32'h00);
    chk("async dp",  {31'd0, dp_out2},  32'd0);
    chk("async q",   {28'd0, class_q2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/class_display_filter.md
Name: class_display_filter

Overview:
- Downstream stage of the perceptron classifier.
- Samples the classifier's 4-bit class output on a slow tick and requires the same value on STABLE_TICKS consecutive ticks before committing it.
- Drives the committed digit onto the 7-segment display and flags unrecognised classes (>9) with a blinking dash.
- Removes flicker while the input switches are moving.

Parameters:
- TICK_COUNT, 24'd10_000_000, clk cycles per sample tick (>=2).
- STABLE_TICKS, 3, consecutive identical samples required to commit (1..15).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design enable; 0 freezes all state
- class_in  input  4  classification from perceptron stage
- seg_out  output  7  segments {g,f,e,d,c,b,a}, active high
- dp_out  output  1  decimal point; 1 = valid digit committed
- class_q  output  4  last committed valid class
- change_pulse  output  1  one-cycle pulse when class_q changes

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: seg_out=0 (blank), dp_out=0, class_q=0, change_pulse=0, prescaler=0, cand=0, stab_cnt=0, blink=0, state=BLANK.
- Prescaler:
  - Counts 0..TICK_COUNT-1 while ena=1.
  - tick=1 for exactly the cycle the count equals TICK_COUNT-1; the count then wraps to 0.
  - ena=0 holds the count, and no tick is generated.
- Sampling, on tick only:
  - If class_in==cand, stab_cnt increments, saturating at STABLE_TICKS.
  - Otherwise cand<=class_in and stab_cnt<=1.
  - The first tick after reset always loads cand, with stab_cnt=1.
- stable: combinational, true on the tick where the next stab_cnt equals STABLE_TICKS. With STABLE_TICKS=1, every tick is stable.
- State machine (states BLANK, SHOW, ERR), evaluated on stable ticks only:
  - Stable value <=9 → state SHOW. If state was not SHOW, or the value differs from class_q: class_q<=value and change_pulse=1 on the next cycle. A stable repeat of the current class_q produces no pulse.
  - Stable value >9 → state ERR. class_q holds. No change_pulse.
  - BLANK is left only on the first stable tick.
- Saturation: once stab_cnt is saturated, every further tick with the same value is still "stable". Re-commit is idempotent: no pulse, no change.
- Blink: blink toggles on every tick while state==ERR; it is cleared to 0 on entry to ERR.
- Outputs: all registered. Latency from the committing tick to seg_out/class_q/change_pulse is 1 clk.
  - BLANK: seg_out=0x00, dp_out=0.
  - SHOW: seg_out=digit(class_q), dp_out=1.
  - ERR: seg_out=blink?0x00:0x40, dp_out=0.
- Digit encoding: 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F.
- ena=0 mid-operation: all registers hold, change_pulse forced to 0, outputs keep their last values.
- rst_n low at any time: immediate return to reset values. The first tick after release comes TICK_COUNT cycles later.
- Input changing between ticks is invisible. Only the value at the tick cycle matters.

Decomposition:
- Shared package perceptron_pkg:
  - state enum {BLANK, SHOW, ERR}
  - SEG_BLANK=7'h00 and SEG_DASH=7'h40
  - digit-to-segment constant table
  - CLASS_MAX=4'd9
- One sub-module: tick_prescaler, parameterised by TICK_COUNT, with inputs clk/rst_n/ena and output tick. It is reusable by other display logic.
- The filter FSM and segment encode stay in class_display_filter.

Test Plan (TICK_COUNT=4, STABLE_TICKS=3 unless noted):
- Reset then class_in=5 held → tick at cycle 4 after release. On the 3rd tick: state SHOW; next clk seg_out=0x6D, dp_out=1, class_q=5, change_pulse high exactly 1 cycle.
- class_in alternates 5,7 on successive ticks for 10 ticks → no commit: seg_out stays 0x00, change_pulse never asserts.
- From committed 5, drive 12 for 3 ticks → seg_out=0x40, then 0x00/0x40 alternating per tick. class_q stays 5, dp_out=0, no pulse. Then 2 for 3 ticks → seg_out=0x5B, class_q=2, one pulse.
- From committed 8, hold 8 for 6 more ticks → no further change_pulse. Glitch class_in to 3 for 1 non-tick cycle only → no effect.
- Deassert ena for 20 cycles mid-count with class_in changed to 4 → prescaler and outputs frozen. After re-enable, commit of 4 happens exactly 3 ticks later.
- STABLE_TICKS=1: class_in=9 → commit on first tick, seg_out=0x6F. Assert rst_n=0 asynchronously mid-SHOW → seg_out=0, dp_out=0, class_q=0 without waiting for a clk edge.
